// File: rtl/bp_be_dcache_resp_checker_pkg.sv
// Shared definitions for the D$ response checker.
// Holds the checker FSM state encoding and the error-cause codes reported
// on error_code_o.
package bp_be_dcache_resp_checker_pkg;

   typedef enum logic [1:0] {
      e_run   = 2'b00,
      e_drain = 2'b01,
      e_done  = 2'b10,
      e_error = 2'b11
   } bp_be_resp_chk_state_e;

   localparam logic [1:0] e_chk_err_none    = 2'b00;
   localparam logic [1:0] e_chk_err_unexp   = 2'b01;
   localparam logic [1:0] e_chk_err_timeout = 2'b10;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small single-read single-write FIFO used as the checker's expected queue.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset (clears pointers)
//   v_i/ready_o/data_i write side; a write happens on v_i & ready_o
//   v_o/data_o/yumi_i  read side; data_o is the head, yumi_i pops it
//   count_o            current occupancy (0..els_p)
// ready_o is simply "not full", so a pop cannot make room for a push in the
// same cycle.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 8,
   parameter int els_p   = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [width_p-1:0]         data_i,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       yumi_i,
   output logic [$clog2(els_p):0]     count_o
);

   localparam int ptr_width_lp = $clog2(els_p);

   logic [width_p-1:0]    mem [els_p];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ptr_width_lp:0] wr_ptr;
   logic [ptr_width_lp:0] rd_ptr;
   logic                  enq;
   logic                  deq;

   assign count_o = wr_ptr - rd_ptr;
   assign v_o     = (count_o != '0);
   assign ready_o = (count_o != (ptr_width_lp+1)'(els_p));
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign data_o  = mem[rd_ptr[ptr_width_lp-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem[wr_ptr[ptr_width_lp-1:0]] <= data_i;
   end

endmodule

// File: rtl/bp_be_dcache_resp_checker.sv
// In-order D$ response scoreboard.
// Expected load data (with a per-byte compare mask) is queued by the trace
// driver; each D$ response pops the head and is compared against it.
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   exp_v_i/exp_ready_o     expected-entry handshake (exp_data_i, exp_mask_i)
//   end_i                   pulse: no further expectations will arrive
//   resp_v_i, resp_data_i   D$ response stream, never stalled
//   mismatch_v_o            one-cycle pulse per mismatching response
//   mismatch_exp_o/_act_o   expected/actual data of the last mismatch
//   pass_count_o/fail_count_o  saturating match/mismatch counts
//   done_o                  sticky: drained cleanly after end_i
//   error_o, error_code_o   sticky protocol error and its cause
module bp_be_dcache_resp_checker
   import bp_be_dcache_resp_checker_pkg::*;
#(
   parameter int dword_width_p = 64,
   parameter int els_p         = 8,
   parameter int timeout_p     = 4096,
   parameter int cnt_width_p   = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       exp_v_i,
   input  logic [dword_width_p-1:0]   exp_data_i,
   input  logic [dword_width_p/8-1:0] exp_mask_i,
   output logic                       exp_ready_o,
   input  logic                       end_i,
   input  logic                       resp_v_i,
   input  logic [dword_width_p-1:0]   resp_data_i,
   output logic                       mismatch_v_o,
   output logic [dword_width_p-1:0]   mismatch_exp_o,
   output logic [dword_width_p-1:0]   mismatch_act_o,
   output logic [cnt_width_p-1:0]     pass_count_o,
   output logic [cnt_width_p-1:0]     fail_count_o,
   output logic                       done_o,
   output logic                       error_o,
   output logic [1:0]                 error_code_o
);

   localparam int mask_width_lp  = dword_width_p/8;
   localparam int fifo_width_lp  = dword_width_p + mask_width_lp;
   localparam int count_width_lp = $clog2(els_p) + 1;
   localparam int tcnt_width_lp  = $clog2(timeout_p) + 1;

   bp_be_resp_chk_state_e state, state_n;
   logic [1:0]            err_code, err_code_n;

   // Queue reset: asserts with reset_n_i, deasserts two clocks after it.
   logic [1:0] reset_sync;
   logic       fifo_reset;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) reset_sync <= '1;
      else            reset_sync <= {reset_sync[0], 1'b0};
   end
   assign fifo_reset = reset_sync[1];

   logic                      fifo_ready;
   logic                      fifo_v;
   logic [fifo_width_lp-1:0]  fifo_data;
   logic [count_width_lp-1:0] fifo_count;
   logic                      q_ready;
   logic                      q_v;
   logic [dword_width_p-1:0]  head_data;
   logic [mask_width_lp-1:0]  head_mask;

   logic active;
   logic enq;
   logic deq;
   logic unexp;
   logic timeout_hit;
   logic mismatch;
   logic [mask_width_lp-1:0]  byte_mismatch;
   logic [tcnt_width_lp-1:0]  tcnt;

   bsg_fifo_1r1w_small #(
      .width_p (fifo_width_lp),
      .els_p   (els_p)
   ) exp_fifo (
      .clk_i   (clk_i),
      .reset_i (fifo_reset),
      .v_i     (enq),
      .ready_o (fifo_ready),
      .data_i  ({exp_mask_i, exp_data_i}),
      .v_o     (fifo_v),
      .data_o  (fifo_data),
      .yumi_i  (deq),
      .count_o (fifo_count)
   );

   // The queue looks empty and unwritable until its synchronous reset has
   // actually taken effect.
   assign q_ready   = fifo_ready & ~fifo_reset;
   assign q_v       = fifo_v & ~fifo_reset;
   assign head_data = fifo_data[dword_width_p-1:0];
   assign head_mask = fifo_data[fifo_width_lp-1 -: mask_width_lp];

   assign exp_ready_o = reset_n_i & q_ready & (state == e_run);
   assign active      = (state == e_run) | (state == e_drain);
   assign enq         = exp_v_i & exp_ready_o;
   // q_v is registered, so an entry written this cycle cannot satisfy a
   // response in the same cycle.
   assign deq         = active & resp_v_i & q_v;
   assign unexp       = active & resp_v_i & ~q_v;
   assign timeout_hit = active & q_v & ~resp_v_i
                        & (tcnt == tcnt_width_lp'(timeout_p - 1));

   always_comb begin
      byte_mismatch = '0;
      for (int unsigned b = 0; b < mask_width_lp; b++) begin
         byte_mismatch[b] = head_mask[b]
                            & (head_data[8*b +: 8] != resp_data_i[8*b +: 8]);
      end
   end
   assign mismatch = |byte_mismatch;

   always_comb begin
      state_n    = state;
      err_code_n = err_code;
      case (state)
         e_run, e_drain: begin
            if (unexp) begin
               state_n    = e_error;
               err_code_n = e_chk_err_unexp;
            end else if (timeout_hit) begin
               state_n    = e_error;
               err_code_n = e_chk_err_timeout;
            end else if (state == e_run) begin
               if (end_i) state_n = e_drain;
            end else if (~q_v | (deq & (fifo_count == count_width_lp'(1)))) begin
               // Look ahead at the last pop so done follows it by one cycle.
               state_n = e_done;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state    <= e_run;
         err_code <= e_chk_err_none;
      end else begin
         state    <= state_n;
         err_code <= err_code_n;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tcnt <= '0;
      end else if (active) begin
         if (resp_v_i | ~q_v) tcnt <= '0;
         else                 tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mismatch_v_o   <= 1'b0;
         mismatch_exp_o <= '0;
         mismatch_act_o <= '0;
         pass_count_o   <= '0;
         fail_count_o   <= '0;
      end else begin
         mismatch_v_o <= deq & mismatch;
         if (deq & mismatch) begin
            mismatch_exp_o <= head_data;
            mismatch_act_o <= resp_data_i;
            if (fail_count_o != '1) fail_count_o <= fail_count_o + 1'b1;
         end
         if (deq & ~mismatch) begin
            if (pass_count_o != '1) pass_count_o <= pass_count_o + 1'b1;
         end
      end
   end

   assign done_o       = (state == e_done);
   assign error_o      = (state == e_error);
   assign error_code_o = err_code;

endmodule
